// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_rx
// Brief    : SPI mode-0 LSB-first byte receiver, oversampled into the local
//            clock domain, with a one-byte valid/ready holding register.
// Revision : 1.0
// ============================================================================
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       SPI_RX_module_clk,
  input  logic       SPI_RX_module_rst_n,
  input  logic       SPI_CLK,
  input  logic       SPI_CS,
  input  logic       SPI_RX,
  output logic [7:0] data_receive,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overrun,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic                   clk_dly_q;
  logic                   cs_dly_q;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       ferr_q, ferr_d;

  logic       w_s_clk, w_s_cs, w_s_rx;
  logic       w_clk_rise, w_cs_fall, w_cs_rise;
  logic       w_byte_done;
  logic [7:0] w_assembled;

  // All three pins share the same depth so data stays aligned with its clock edge
  always_ff @(posedge SPI_RX_module_clk or negedge SPI_RX_module_rst_n) begin
    if (!SPI_RX_module_rst_n) begin
      clk_sync_q <= '0;
      cs_sync_q  <= '1;
      rx_sync_q  <= '0;
      clk_dly_q  <= 1'b0;
      cs_dly_q   <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
      rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], SPI_RX};
      clk_dly_q  <= clk_sync_q[SYNC_STAGES-1];
      cs_dly_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign w_s_clk     = clk_sync_q[SYNC_STAGES-1];
  assign w_s_cs      = cs_sync_q[SYNC_STAGES-1];
  assign w_s_rx      = rx_sync_q[SYNC_STAGES-1];
  assign w_clk_rise  = w_s_clk & ~clk_dly_q;
  assign w_cs_fall   = ~w_s_cs & cs_dly_q;
  assign w_cs_rise   = w_s_cs & ~cs_dly_q;
  assign w_assembled = {w_s_rx, shreg_q[7:1]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    ferr_d      = 1'b0;
    w_byte_done = 1'b0;

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_cs_fall) begin
          state_d   = ST_RECV;
          bit_cnt_d = 3'd0;
          shreg_d   = 8'h00;
        end
      end
      ST_RECV: begin
        if (w_clk_rise) begin
          shreg_d     = w_assembled;
          bit_cnt_d   = bit_cnt_q + 3'd1;
          w_byte_done = (bit_cnt_q == 3'd7);
        end
        // CS rule sees the post-shift count, so an 8th bit coinciding with CS rise is a clean byte
        if (w_cs_rise) begin
          state_d   = ST_IDLE;
          ferr_d    = (bit_cnt_d != 3'd0);
          bit_cnt_d = 3'd0;
          shreg_d   = 8'h00;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_byte_done) begin
      if (!valid_q || data_ready) begin
        data_d  = w_assembled;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge SPI_RX_module_clk or negedge SPI_RX_module_rst_n) begin
    if (!SPI_RX_module_rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_receive = data_q;
  assign data_valid   = valid_q;
  assign overrun      = overrun_q;
  assign frame_error  = ferr_q;
  assign busy         = (state_q == ST_RECV);

endmodule
`default_nettype wire
